// File: rtl/rambam_pkg.sv
// rtl/rambam_pkg.sv - shared FSM state type, step count and element width helper
package rambam_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int STEP_COUNT = 13;

   function automatic int elem_width(input int d);
      return 8 + d;
   endfunction

endpackage

// File: rtl/sbox_power_map_if.sv
// rtl/sbox_power_map_if.sv - operand/result handshake bundle for sbox_power_map
interface sbox_power_map_if #(parameter int d = 4);

   logic [0:7+d] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [0:7+d] out_data;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/ring_mul.sv
// rtl/ring_mul.sv - combinational a*b mod P in GF(2)[x]/P, MSB-first Horner reduction
module ring_mul
   import rambam_pkg::*;
#(
   parameter int           d = 4,
   parameter logic [0:8+d] P = 'h11B
) (
   input  logic [0:7+d] a,
   input  logic [0:7+d] b,
   output logic [0:7+d] y
);

   localparam int N = elem_width(d);
   localparam logic [N:0]   PV   = P;
   localparam logic [N-1:0] PLOW = PV[N-1:0];

   logic [N-1:0] av;
   logic [N-1:0] bv;
   logic [N-1:0] r;

   always_comb begin
      av = a;
      bv = b;
      r  = '0;
      // Shift-and-add from the top coefficient; an overflow past x^(N-1) folds back via P
      for (int i = N - 1; i >= 0; i--) begin
         r = r[N-1] ? ((r << 1) ^ PLOW) : (r << 1);
         if (bv[i]) r = r ^ av;
      end
      y = r;
   end

endmodule

// File: rtl/sbox_power_map.sv
// rtl/sbox_power_map.sv - x^254 mod P by fixed 13-step square/multiply chain
// SBOX_POWER_MAP_ZEROIZE_EN: clear acc and base on the output handshake
module sbox_power_map
   import rambam_pkg::*;
#(
   parameter int           d = 4,
   parameter logic [0:8+d] P = 'h11B
) (
   input  logic            clk,
   input  logic            rst,
   sbox_power_map_if.slave bus
);

   localparam int N = elem_width(d);

   state_t       state;
   logic [3:0]   cnt;
   logic [0:N-1] acc;
   logic [0:N-1] base;
   logic [0:N-1] mul_b;
   logic [0:N-1] prod;
   logic         out_valid_q;
   logic         in_ready_q;

   // Even steps square, odd steps multiply by the latched base
   assign mul_b = cnt[0] ? base : acc;

   ring_mul #(.d(d), .P(P)) u_mul (
      .a (acc),
      .b (mul_b),
      .y (prod)
   );

   assign bus.out_data  = acc;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         base        <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  base       <= bus.in_data;
                  acc        <= bus.in_data;
                  cnt        <= '0;
                  in_ready_q <= 1'b0;
                  state      <= CALC;
               end
            end
            CALC: begin
               acc <= prod;
               if (cnt == 4'(STEP_COUNT - 1)) begin
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
`ifdef SBOX_POWER_MAP_ZEROIZE_EN
                  acc  <= '0;
                  base <= '0;
`else
                  acc  <= acc;
                  base <= base;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
